pc_fetch_ctrl: RTL and testbench
================================

Name: pc_fetch_ctrl

Overview:
Program counter register and fetch controller sitting directly upstream of the PC adder. It drives PCResult to the adder and to instruction memory, and consumes PCAddResult (PC+4) as the sequential next PC. It also selects branch or jump redirects, honours pipeline stalls, and runs a valid/ready fetch handshake with instruction memory.

Parameters:
RESET_VECTOR, 32'h00000000, PC value loaded on reset; must be word-aligned.
ADDR_W, 32, PC/address width.

Ports:
Clk  input  1  system clock, rising-edge.
Reset  input  1  asynchronous, active-low reset.
PCAddResult  input  ADDR_W  PC+4 from adder; sequential next PC.
BranchTaken  input  1  branch redirect request, sampled each cycle.
BranchTarget  input  ADDR_W  branch target address.
Jump  input  1  jump redirect request.
JumpTarget  input  ADDR_W  jump target address.
Stall  input  1  hazard stall; freezes PC.
FetchReady  input  1  instruction memory accepts the current request.
PCResult  output  ADDR_W  current PC, registered.
FetchValid  output  1  fetch request valid at PCResult.
Misaligned  output  1  sticky flag: a redirect target had bits [1:0] != 0.

Behaviour:
- Reset (Reset=0, asynchronous): PCResult=RESET_VECTOR, FetchValid=0, Misaligned=0, state=BOOT.
- States: BOOT, FETCH, HOLD, ERROR. All outputs are registered.
- BOOT: lasts 1 cycle after reset release. FetchValid=0. Then goes to FETCH (or HOLD if Stall=1).
- FETCH: FetchValid=1.
  - Handshake fires when FetchValid && FetchReady && !Stall. PC then advances to the next PC on the same edge.
  - If FetchReady=0, PCResult and FetchValid are held stable (no change while waiting).
- Next-PC priority: Jump > BranchTaken > sequential PCAddResult.
- A redirect (Jump or BranchTaken) takes effect on the next edge even if FetchReady=0.
  - The outstanding request is abandoned and PCResult loads the target.
  - FetchValid stays 1 with the new address.
  - A redirect is ignored while Stall=1; the upstream source must hold it.
- Stall=1 in FETCH: go to HOLD next edge. FetchValid=0 and PCResult is frozen. A handshake is never completed while Stall=1.
- HOLD: return to FETCH on the first cycle Stall=0. PCResult is unchanged.
- Alignment check: applied only to the selected redirect target (bits [1:0] != 0).
  - On failure: PCResult is not updated, Misaligned=1, FetchValid=0, state=ERROR.
- ERROR: terminal; all inputs ignored until Reset asserts.
- Sequential path: PCAddResult is trusted; 32'hFFFFFFFC + 4 wraps to 32'h00000000 with no flag.
- Simultaneous Jump and BranchTaken: Jump wins; the branch is dropped silently.
- Reset mid-handshake: immediate return to the reset state; the pending request is lost.

Optional Feature:
Macro PC_REDIRECT_CNT_EN.
- Defined: adds output RedirectCount [15:0].
  - Increments on each accepted redirect (Jump or BranchTaken applied, aligned, not stalled).
  - Saturates at 16'hFFFF; reset value 0.
- Undefined: port and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package pc_fetch_pkg:
  - state enum {BOOT, FETCH, HOLD, ERROR}
  - ADDR_W default
  - next-PC select encoding {SEL_SEQ, SEL_BRANCH, SEL_JUMP}
  - ALIGN_MASK = 2'b11
- One sub-module, pc_next_sel: combinational priority mux plus alignment check. Outputs the next PC, the select code, and a misaligned indication.
- The FSM and PC register stay in pc_fetch_ctrl.

Test Plan:
1. Reset, release, FetchReady=1, adder model PC+4 → BOOT for 1 cycle with FetchValid=0, then PCResult = 0x0, 0x4, 0x8 on successive edges.
2. FetchReady=0 for 3 cycles at PC=0x20 → PCResult held at 0x20 with FetchValid=1. FetchReady=1 → next edge PC=0x24.
3. Jump=1, JumpTarget=0x100, BranchTaken=1, BranchTarget=0x200, FetchReady=0 → next PC=0x100; RedirectCount=1 if PC_REDIRECT_CNT_EN.
4. Stall=1 for 2 cycles at PC=0x40 → FetchValid=0 and PC=0x40 throughout. Stall=0 → FetchValid=1 at 0x40, then advances to 0x44.
5. BranchTaken=1, BranchTarget=0x102 → Misaligned=1, PC unchanged, FetchValid=0. Further redirects are ignored until Reset=0.
6. Sequential advance from PC=0xFFFFFFFC → wraps to 0x00000000, Misaligned stays 0. Assert Reset mid-handshake → PCResult returns to RESET_VECTOR asynchronously.

Source files
------------

// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the PC fetch controller: FSM states,
// next-PC select encoding and the word-alignment mask.
package pc_fetch_pkg;

  localparam int DEFAULT_ADDR_W = 32;

  localparam logic [1:0] ALIGN_MASK = 2'b11;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    ERROR = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SEL_SEQ    = 2'd0,
    SEL_BRANCH = 2'd1,
    SEL_JUMP   = 2'd2
  } sel_t;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority mux (jump > branch > sequential) with an alignment check
// that looks only at the selected redirect target.
module pc_next_sel
  import pc_fetch_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic [ADDR_W-1:0] pc_add,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  output logic [ADDR_W-1:0] next_pc,
  output sel_t              sel,
  output logic              misaligned
);

  always_comb begin
    next_pc = pc_add;
    sel     = SEL_SEQ;
    if (jump) begin
      next_pc = jump_target;
      sel     = SEL_JUMP;
    end else if (branch_taken) begin
      next_pc = branch_target;
      sel     = SEL_BRANCH;
    end
    // The adder output is trusted, so only redirect targets are checked.
    misaligned = (sel != SEL_SEQ) && ((next_pc[1:0] & ALIGN_MASK) != 2'b00);
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC register and fetch FSM (BOOT/FETCH/HOLD/ERROR) feeding the PC adder and
// instruction memory. Define PC_REDIRECT_CNT_EN to add the RedirectCount output.
module pc_fetch_ctrl
  import pc_fetch_pkg::*;
#(
  parameter int                ADDR_W       = DEFAULT_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] PCAddResult,
  input  logic              BranchTaken,
  input  logic [ADDR_W-1:0] BranchTarget,
  input  logic              Jump,
  input  logic [ADDR_W-1:0] JumpTarget,
  input  logic              Stall,
  input  logic              FetchReady,
  output logic [ADDR_W-1:0] PCResult,
  output logic              FetchValid,
  output logic              Misaligned,
`ifdef PC_REDIRECT_CNT_EN
  output logic [15:0]       RedirectCount,
`endif
  output state_t            dbg_state
);

  state_t            state;
  logic [ADDR_W-1:0] next_pc;
  sel_t              sel;
  logic              sel_mis;
  logic              redirect;
  logic              fire;

  pc_next_sel #(.ADDR_W(ADDR_W)) u_next_sel (
    .pc_add        (PCAddResult),
    .branch_taken  (BranchTaken),
    .branch_target (BranchTarget),
    .jump          (Jump),
    .jump_target   (JumpTarget),
    .next_pc       (next_pc),
    .sel           (sel),
    .misaligned    (sel_mis)
  );

  // Fetch handshake: a request at PCResult is offered while FetchValid=1 and
  // completes on an edge where FetchReady=1 and Stall=0; until then PCResult
  // and FetchValid hold. A redirect abandons the open request instead.
  assign redirect  = (sel != SEL_SEQ);
  assign fire      = FetchValid && FetchReady && !Stall;
  assign dbg_state = state;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state      <= BOOT;
      PCResult   <= RESET_VECTOR;
      FetchValid <= 1'b0;
      Misaligned <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          if (Stall) begin
            state <= HOLD;
          end else begin
            state      <= FETCH;
            FetchValid <= 1'b1;
          end
        end
        FETCH: begin
          if (Stall) begin
            state      <= HOLD;
            FetchValid <= 1'b0;
          end else if (redirect) begin
            if (sel_mis) begin
              state      <= ERROR;
              FetchValid <= 1'b0;
              Misaligned <= 1'b1;
            end else begin
              PCResult <= next_pc;
            end
          end else if (fire) begin
            PCResult <= next_pc;
          end
        end
        HOLD: begin
          if (!Stall) begin
            state      <= FETCH;
            FetchValid <= 1'b1;
          end
        end
        ERROR: begin
          state <= ERROR;
        end
        default: begin
          state      <= ERROR;
          FetchValid <= 1'b0;
        end
      endcase
    end
  end

`ifdef PC_REDIRECT_CNT_EN
  logic accept_redirect;
  assign accept_redirect = (state == FETCH) && !Stall && redirect && !sel_mis;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      RedirectCount <= 16'h0000;
    end else if (accept_redirect && (RedirectCount != 16'hFFFF)) begin
      RedirectCount <= RedirectCount + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed, table-driven bench for pc_fetch_ctrl with an ideal PC+4 adder model
// and hand-written sequences for async reset and redirect priority corners.
module tb_pc_fetch_ctrl;
  import pc_fetch_pkg::*;

  logic        Clk;
  logic        Reset;
  logic [31:0] PCAddResult;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic        Jump;
  logic [31:0] JumpTarget;
  logic        Stall;
  logic        FetchReady;
  logic [31:0] PCResult;
  logic        FetchValid;
  logic        Misaligned;
`ifdef PC_REDIRECT_CNT_EN
  logic [15:0] RedirectCount;
`endif
  state_t      dbg_state;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        jump;
    logic [31:0] jtgt;
    logic        br;
    logic [31:0] btgt;
    logic        stall;
    logic        ready;
    logic [31:0] exp_pc;
    logic        exp_fv;
    logic        exp_mis;
    state_t      exp_st;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vq[$];

  pc_fetch_ctrl #(.ADDR_W(32), .RESET_VECTOR(32'h0000_0000)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .PCAddResult  (PCAddResult),
    .BranchTaken  (BranchTaken),
    .BranchTarget (BranchTarget),
    .Jump         (Jump),
    .JumpTarget   (JumpTarget),
    .Stall        (Stall),
    .FetchReady   (FetchReady),
    .PCResult     (PCResult),
    .FetchValid   (FetchValid),
    .Misaligned   (Misaligned),
`ifdef PC_REDIRECT_CNT_EN
    .RedirectCount(RedirectCount),
`endif
    .dbg_state    (dbg_state)
  );

  // Ideal adder: wraps modulo 2^32.
  assign PCAddResult = PCResult + 32'd4;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic vec_t mk(input logic jump, input logic [31:0] jtgt,
                              input logic br, input logic [31:0] btgt,
                              input logic stall, input logic ready,
                              input logic [31:0] exp_pc, input logic exp_fv,
                              input logic exp_mis, input state_t exp_st,
                              input logic [15:0] exp_cnt);
    vec_t v;
    v.jump = jump;  v.jtgt = jtgt;  v.br = br;  v.btgt = btgt;
    v.stall = stall;  v.ready = ready;
    v.exp_pc = exp_pc;  v.exp_fv = exp_fv;  v.exp_mis = exp_mis;
    v.exp_st = exp_st;  v.exp_cnt = exp_cnt;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [31:0] epc, input logic efv,
                               input logic emis, input state_t est, input logic [15:0] ecnt);
    check({tag, " pc"}, PCResult, epc);
    check({tag, " fv"}, {31'h0, FetchValid}, {31'h0, efv});
    check({tag, " mis"}, {31'h0, Misaligned}, {31'h0, emis});
    check({tag, " st"}, {30'h0, dbg_state}, {30'h0, est});
`ifdef PC_REDIRECT_CNT_EN
    check({tag, " cnt"}, {16'h0, RedirectCount}, {16'h0, ecnt});
`else
    if (ecnt == 16'hFFFF) $display("note: %s count not checked", tag);
`endif
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    Jump = v.jump;  JumpTarget = v.jtgt;
    BranchTaken = v.br;  BranchTarget = v.btgt;
    Stall = v.stall;  FetchReady = v.ready;
    @(posedge Clk);
    #1;
    check_outputs(tag, v.exp_pc, v.exp_fv, v.exp_mis, v.exp_st, v.exp_cnt);
  endtask

  task automatic clear_inputs();
    Jump = 1'b0;  JumpTarget = '0;  BranchTaken = 1'b0;  BranchTarget = '0;
    Stall = 1'b0;  FetchReady = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    Reset = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b1;
  endtask

  initial begin
    clear_inputs();
    Reset = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    check_outputs("reset", 32'h0, 1'b0, 1'b0, BOOT, 16'd0);
    Reset = 1'b1;

    // jump, jtgt, br, btgt, stall, ready -> pc, fv, mis, state, count
    vq.push_back(mk(0, 32'h0,        0, 32'h0,   0, 1, 32'h0000_0000, 1, 0, FETCH, 16'd0));
    vq.push_back(mk(0, 32'h0,        0, 32'h0,   0, 1, 32'h0000_0004, 1, 0, FETCH, 16'd0));
    vq.push_back(mk(0, 32'h0,        0, 32'h0,   0, 1, 32'h0000_0008, 1, 0, FETCH, 16'd0));
    vq.push_back(mk(1, 32'h20,       0, 32'h0,   0, 0, 32'h0000_0020, 1, 0, FETCH, 16'd1));
    vq.push_back(mk(0, 32'h0,        0, 32'h0,   0, 0, 32'h0000_0020, 1, 0, FETCH, 16'd1));
    vq.push_back(mk(0, 32'h0,        0, 32'h0,   0, 0, 32'h0000_0020, 1, 0, FETCH, 16'd1));
    vq.push_back(mk(0, 32'h0,        0, 32'h0,   0, 0, 32'h0000_0020, 1, 0, FETCH, 16'd1));
    vq.push_back(mk(0, 32'h0,        0, 32'h0,   0, 1, 32'h0000_0024, 1, 0, FETCH, 16'd1));
    vq.push_back(mk(1, 32'h100,      1, 32'h200, 0, 0, 32'h0000_0100, 1, 0, FETCH, 16'd2));
    vq.push_back(mk(0, 32'h0,        1, 32'h40,  0, 0, 32'h0000_0040, 1, 0, FETCH, 16'd3));
    vq.push_back(mk(0, 32'h0,        0, 32'h0,   1, 1, 32'h0000_0040, 0, 0, HOLD,  16'd3));
    vq.push_back(mk(1, 32'h300,      0, 32'h0,   1, 1, 32'h0000_0040, 0, 0, HOLD,  16'd3));
    vq.push_back(mk(0, 32'h0,        0, 32'h0,   0, 1, 32'h0000_0040, 1, 0, FETCH, 16'd3));
    vq.push_back(mk(0, 32'h0,        0, 32'h0,   0, 1, 32'h0000_0044, 1, 0, FETCH, 16'd3));
    vq.push_back(mk(0, 32'h0,        1, 32'h1000,0, 1, 32'h0000_1000, 1, 0, FETCH, 16'd4));
    vq.push_back(mk(0, 32'h0,        1, 32'h102, 1, 1, 32'h0000_1000, 0, 0, HOLD,  16'd4));
    vq.push_back(mk(0, 32'h0,        0, 32'h0,   0, 1, 32'h0000_1000, 1, 0, FETCH, 16'd4));
    vq.push_back(mk(1, 32'hFFFF_FFFC,0, 32'h0,   0, 1, 32'hFFFF_FFFC, 1, 0, FETCH, 16'd5));
    vq.push_back(mk(0, 32'h0,        0, 32'h0,   0, 1, 32'h0000_0000, 1, 0, FETCH, 16'd5));
    vq.push_back(mk(0, 32'h0,        0, 32'h0,   0, 1, 32'h0000_0004, 1, 0, FETCH, 16'd5));
    vq.push_back(mk(0, 32'h0,        1, 32'h102, 0, 1, 32'h0000_0004, 0, 1, ERROR, 16'd5));
    vq.push_back(mk(1, 32'h200,      0, 32'h0,   0, 1, 32'h0000_0004, 0, 1, ERROR, 16'd5));
    vq.push_back(mk(0, 32'h0,        0, 32'h0,   0, 1, 32'h0000_0004, 0, 1, ERROR, 16'd5));

    foreach (vq[i]) run_vec($sformatf("v%0d", i), vq[i]);

    // Jump beats a misaligned branch; then async reset in the middle of a cycle.
    do_reset();
    run_vec("b0", mk(0, 32'h0,   0, 32'h0,   0, 1, 32'h0000_0000, 1, 0, FETCH, 16'd0));
    run_vec("b1", mk(1, 32'h300, 1, 32'h103, 0, 0, 32'h0000_0300, 1, 0, FETCH, 16'd1));
    run_vec("b2", mk(0, 32'h0,   0, 32'h0,   0, 1, 32'h0000_0304, 1, 0, FETCH, 16'd1));
    FetchReady = 1'b1;
    #2;
    Reset = 1'b0;
    #1;
    check_outputs("async_rst", 32'h0, 1'b0, 1'b0, BOOT, 16'd0);
    @(posedge Clk);
    #1;
    check_outputs("rst_hold", 32'h0, 1'b0, 1'b0, BOOT, 16'd0);

    // Stall during BOOT goes to HOLD; a misaligned jump wins over an aligned branch.
    do_reset();
    run_vec("c0", mk(0, 32'h0,   0, 32'h0,   1, 1, 32'h0000_0000, 0, 0, HOLD,  16'd0));
    run_vec("c1", mk(0, 32'h0,   0, 32'h0,   0, 1, 32'h0000_0000, 1, 0, FETCH, 16'd0));
    run_vec("c2", mk(1, 32'h101, 1, 32'h200, 0, 1, 32'h0000_0000, 0, 1, ERROR, 16'd0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
